audio_out_stage: RTL and testbench

- Downstream of the sound-toy core's PCM output; drives the frame's AUDIO_L/AUDIO_R.
- Buffers PCM samples from the core in a small FIFO and releases them at an exact fixed output rate derived from the 50 MHz system clock.
- Applies a click-free gain ramp for volume changes, mute and power-up.
- Reports underruns so the sound engine's pacing can be checked on hardware.

---
 rtl/audio_out_pkg.sv | 38 +++
 rtl/audio_out_fifo.sv | 54 +++++
 rtl/audio_out_stage.sv | 160 ++++++++++++++++
 tb/tb_audio_out_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// audio_out_pkg: shared widths, saturation limits, gain FSM states and the
// scale/saturate helper for the audio output stage.
package audio_out_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int GAIN_W     = 8;
   localparam int GAIN_UNITY = 128;
   localparam int GAIN_SHIFT = 7;                      // log2(GAIN_UNITY)
   localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;  // s16 x s9 -> s25

   localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

   localparam logic signed [PROD_W-1:0] SAT_MAX_W = 25'sd32767;
   localparam logic signed [PROD_W-1:0] SAT_MIN_W = -25'sd32768;

   typedef enum logic [1:0] {
      STEADY,
      RAMP_UP,
      RAMP_DOWN
   } gain_state_t;

   // Drop the unity-gain fraction bits (arithmetic shift, rounds toward -inf)
   // and clamp into the 16-bit PCM range.
   function automatic logic signed [SAMPLE_W-1:0] sat_scale(
      input logic signed [PROD_W-1:0] prod
   );
      logic signed [PROD_W-1:0] sh;
      sh = prod >>> GAIN_SHIFT;
      if (sh > SAT_MAX_W)
         return SAT_MAX;
      else if (sh < SAT_MIN_W)
         return SAT_MIN;
      else
         return sh[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/audio_out_fifo.sv
// audio_out_fifo: small synchronous sample FIFO.
// Ports: clk, reset (async, active high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o is the head entry, so it is captured on
// the same edge that pops it), full_o, empty_o, level_o (entry count).
module audio_out_fifo #(
   parameter int  DEPTH = 16,
   parameter int  W     = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q;
   logic          do_push, do_pop;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage needs no reset: level_q gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)
            level_q <= level_q + (AW+1)'(1);
         else if (!do_push && do_pop)
            level_q <= level_q - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/audio_out_stage.sv
// audio_out_stage: buffers PCM samples from the core and releases them at an
// exact SAMPLE_HZ rate derived from CLK_HZ, with a click-free gain ramp.
// Ports: clk, reset (async, active high); in_valid/in_ready/in_sample input
// handshake; volume (128 = unity), mute; out_sample/out_strobe PCM output;
// muted, ramping status; fifo_level; underrun_cnt (saturating).
module audio_out_stage
   import audio_out_pkg::*;
#(
   parameter int  CLK_HZ     = 50000000,
   parameter int  SAMPLE_HZ  = 48000,
   parameter int  FIFO_DEPTH = 16,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [SAMPLE_W-1:0] in_sample,
   input  logic        [GAIN_W-1:0]   volume,
   input  logic                       mute,
   output logic signed [SAMPLE_W-1:0] out_sample,
   output logic                       out_strobe,
   output logic                       muted,
   output logic                       ramping,
   output logic        [LVL_W-1:0]    fifo_level,
   output logic        [15:0]         underrun_cnt
);

   localparam int ACC_W = 27;

   // ---------------- rate tick ----------------
   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic             tick;

   // Fractional-N accumulator: exactly SAMPLE_HZ ticks per CLK_HZ cycles.
   always_comb begin
      acc_sum = acc_q + ACC_W'(SAMPLE_HZ);
      tick    = (acc_sum >= ACC_W'(CLK_HZ));
      acc_d   = tick ? (acc_sum - ACC_W'(CLK_HZ)) : acc_sum;
   end

   // ---------------- FIFO ----------------
   logic                fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0] fifo_rdata;
   logic                push, pop;
   logic                in_ready_q, in_ready_d;
   logic                full_nxt;

   assign push = in_valid && in_ready_q;
   assign pop  = tick && !fifo_empty;

   // in_ready is registered, so it must look at the level after this edge;
   // otherwise a push could land on an already full FIFO.
   assign full_nxt   = (fifo_full && !pop) ||
                       ((fifo_level == LVL_W'(FIFO_DEPTH - 1)) && push && !pop);
   assign in_ready_d = !full_nxt;

   audio_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SAMPLE_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .wdata_i (in_sample),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // ---------------- held sample / underrun ----------------
   logic signed [SAMPLE_W-1:0] held_q, held_d;
   logic [15:0]                und_q, und_d;

   always_comb begin
      held_d = held_q;
      und_d  = und_q;
      if (pop)
         held_d = $signed(fifo_rdata);
      else if (tick && und_q != 16'hFFFF)
         und_d = und_q + 16'd1;   // empty on tick: repeat the last sample
   end

   // ---------------- gain FSM ----------------
   gain_state_t       state_q, state_d;
   logic [GAIN_W-1:0] gain_q, gain_d, target;
   logic              muted_q, muted_d;

   assign target = mute ? '0 : volume;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= STEADY;
      else       state_q <= state_d;
   end

   // The step direction depends only on where the target sits relative to g,
   // so every state follows the same rule; the state records whether g was
   // still short of the target after the last tick.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (tick) begin
         if (target > gain_q) begin
            gain_d  = gain_q + 8'd1;
            state_d = (gain_d == target) ? STEADY : RAMP_UP;
         end else if (target < gain_q) begin
            gain_d  = gain_q - 8'd1;
            state_d = (gain_d == target) ? STEADY : RAMP_DOWN;
         end else begin
            state_d = STEADY;
         end
      end
   end

   always_comb begin
      ramping = (state_q != STEADY);
   end

   assign muted_d = mute && (gain_d == '0);

   // ---------------- scale / saturate ----------------
   logic [1:0]                 vld_pipe_q;   // [0]: tick edge done, [1]: strobe
   logic signed [PROD_W-1:0]   prod;
   logic signed [SAMPLE_W-1:0] out_q;

   // Uses held/g as updated on the tick edge, one cycle later.
   assign prod = $signed({{(GAIN_W+1){held_q[SAMPLE_W-1]}}, held_q}) *
                 $signed({{(SAMPLE_W+1){1'b0}}, gain_q});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         in_ready_q <= 1'b0;
         held_q     <= '0;
         und_q      <= '0;
         gain_q     <= '0;
         muted_q    <= 1'b0;
         vld_pipe_q <= '0;
         out_q      <= '0;
      end else begin
         acc_q      <= acc_d;
         in_ready_q <= in_ready_d;
         held_q     <= held_d;
         und_q      <= und_d;
         gain_q     <= gain_d;
         muted_q    <= muted_d;
         vld_pipe_q <= {vld_pipe_q[0], tick};
         if (vld_pipe_q[0]) out_q <= sat_scale(prod);
      end
   end

   assign in_ready     = in_ready_q;
   assign out_sample   = out_q;
   assign out_strobe   = vld_pipe_q[1];
   assign muted        = muted_q;
   assign underrun_cnt = und_q;

endmodule

// File: tb/tb_audio_out_stage.sv
// Bench for audio_out_stage. A default-rate instance checks the exact tick
// timing and FIFO fill/drain; a fast-rate instance is compared every cycle
// against a queue-based reference model under directed and random stimulus.
module tb_audio_out_stage;

   localparam int F_CLK = 1000;
   localparam int F_SR  = 93;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- default-rate instance ----------------
   logic               d_rst, d_valid, d_ready, d_mute, d_strobe, d_muted, d_ramp;
   logic signed [15:0] d_sample, d_out;
   logic        [7:0]  d_vol;
   logic        [4:0]  d_level;
   logic        [15:0] d_und;

   audio_out_stage u_def (
      .clk(clk), .reset(d_rst), .in_valid(d_valid), .in_ready(d_ready),
      .in_sample(d_sample), .volume(d_vol), .mute(d_mute),
      .out_sample(d_out), .out_strobe(d_strobe), .muted(d_muted),
      .ramping(d_ramp), .fifo_level(d_level), .underrun_cnt(d_und)
   );

   // ---------------- fast-rate instance ----------------
   logic               f_rst, f_valid, f_ready, f_mute, f_strobe, f_muted, f_ramp;
   logic signed [15:0] f_sample, f_out;
   logic        [7:0]  f_vol;
   logic        [4:0]  f_level;
   logic        [15:0] f_und;

   audio_out_stage #(.CLK_HZ(F_CLK), .SAMPLE_HZ(F_SR), .FIFO_DEPTH(DEPTH)) u_fast (
      .clk(clk), .reset(f_rst), .in_valid(f_valid), .in_ready(f_ready),
      .in_sample(f_sample), .volume(f_vol), .mute(f_mute),
      .out_sample(f_out), .out_strobe(f_strobe), .muted(f_muted),
      .ramping(f_ramp), .fifo_level(f_level), .underrun_cnt(f_und)
   );

   // ---------------- reference model (fast instance) ----------------
   int m_n, m_ticks, m_held, m_g, m_tgt, m_out, m_und;
   int m_q[$];
   bit m_strobe, m_pend, m_rdy, m_muted, m_ramp;

   // Tick on edge n when the count of whole sample periods elapsed by edge n grows.
   function automatic bit tick_at(input int n);
      longint a, b;
      a = (longint'(n) * F_SR) / F_CLK;
      b = (longint'(n - 1) * F_SR) / F_CLK;
      return a != b;
   endfunction

   function automatic int sat16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic m_reset();
      m_n = 0; m_ticks = 0; m_held = 0; m_g = 0; m_tgt = 0; m_out = 0; m_und = 0;
      m_q.delete();
      m_strobe = 0; m_pend = 0; m_rdy = 0; m_muted = 0; m_ramp = 0;
   endtask

   // Effect of one rising edge with the inputs currently driven.
   task automatic m_edge();
      bit push, tk;
      push = f_valid && m_rdy;
      m_n++;
      tk = tick_at(m_n);
      m_strobe = m_pend;
      if (m_pend) m_out = sat16((m_held * m_g) >>> 7);
      m_pend = tk;
      if (tk) begin
         m_ticks++;
         if (m_q.size() > 0) m_held = m_q.pop_front();
         else if (m_und < 65535) m_und++;
         m_tgt = f_mute ? 0 : int'(f_vol);
         if (m_g < m_tgt) m_g++;
         else if (m_g > m_tgt) m_g--;
         m_ramp = (m_g != m_tgt);
      end
      if (push) m_q.push_back(int'(f_sample));
      m_muted = f_mute && (m_g == 0);
      m_rdy = (m_q.size() < DEPTH);
   endtask

   task automatic f_cmp();
      chk("f_strobe",   f_strobe, m_strobe);
      chk("f_out",      f_out,    m_out);
      chk("f_ready",    f_ready,  m_rdy);
      chk("f_level",    f_level,  m_q.size());
      chk("f_ramping",  f_ramp,   m_ramp);
      chk("f_muted",    f_muted,  m_muted);
      chk("f_underrun", f_und,    m_und);
   endtask

   // Called at a falling edge: predict the next rising edge, then compare.
   task automatic f_step();
      m_edge();
      @(negedge clk);
      f_cmp();
   endtask

   task automatic f_do_reset();
      f_rst = 1'b1;
      #1;
      m_reset();
      f_cmp();
      chk("f_rst_level", f_level, 0);
      chk("f_rst_out", f_out, 0);
      @(negedge clk);
      f_rst = 1'b0;
   endtask

   task automatic run_strobes(input int n);
      int k;
      k = 0;
      for (int c = 0; c < n * 20 && k < n; c++) begin
         f_step();
         if (f_strobe) k++;
      end
      chk("strobe_budget", k, n);
   endtask

   initial begin
      d_rst = 1'b1; d_valid = 1'b0; d_sample = '0; d_vol = 8'd128; d_mute = 1'b0;
      f_rst = 1'b1; f_valid = 1'b0; f_sample = '0; f_vol = 8'd128; f_mute = 1'b0;
      m_reset();
      fork
         // ---------- default-rate directed tests ----------
         begin : def_tests
            int ns, last;
            @(negedge clk);
            chk("d_rst_out", d_out, 0);     chk("d_rst_strobe", d_strobe, 0);
            chk("d_rst_ready", d_ready, 0); chk("d_rst_level", d_level, 0);
            chk("d_rst_und", d_und, 0);     chk("d_rst_ramp", d_ramp, 0);
            chk("d_rst_muted", d_muted, 0);
            d_rst = 1'b0;
            ns = 0; last = 0;
            for (int e = 1; e <= 6300 && ns < 5; e++) begin
               @(negedge clk);
               if (e == 1) chk("d_ready_edge1", d_ready, 1);
               if (d_strobe) begin
                  ns++;
                  if (ns == 1) begin
                     chk("d_first_strobe_edge", e, 1043);
                     chk("d_first_out", d_out, 0);
                  end else begin
                     chk("d_spacing_ok", (e - last == 1041) || (e - last == 1042), 1);
                  end
                  chk("d_underrun", d_und, ns);
                  last = e;
               end
            end
            chk("d_strobe_count", ns, 5);

            // FIFO fill with no tick pending, then drain by one tick
            d_rst = 1'b1;
            @(negedge clk);
            d_rst = 1'b0;
            @(negedge clk);                       // edge 1
            chk("d_fill_ready0", d_ready, 1);
            d_valid = 1'b1; d_sample = 16'sd1000;
            for (int p = 1; p <= 17; p++) begin   // edges 2..18; 17th push ignored
               @(negedge clk);
               chk("d_fill_level", d_level, (p < 16) ? p : 16);
               chk("d_fill_ready", d_ready, (p < 16) ? 1 : 0);
            end
            d_valid = 1'b0;
            repeat (1041 - 18) @(negedge clk);    // after edge 1041
            chk("d_full_level", d_level, 16);
            chk("d_full_ready", d_ready, 0);
            @(negedge clk);                       // edge 1042: tick pops one
            chk("d_pop_level", d_level, 15);
            chk("d_pop_ready", d_ready, 1);
            @(negedge clk);                       // edge 1043: strobe, g=1
            chk("d_pop_strobe", d_strobe, 1);
            chk("d_pop_out", d_out, 7);
            chk("d_pop_und", d_und, 0);
         end
         // ---------- fast-rate model-checked tests ----------
         begin : fast_tests
            int k;
            @(negedge clk);
            f_do_reset();
            // fade-in from power-up, constant 12800
            f_valid = 1'b1; f_sample = 16'sd12800;
            k = 0;
            for (int c = 0; c < 3000 && k < 140; c++) begin
               f_step();
               if (f_strobe) begin
                  k++;
                  chk("fadein_out", f_out, (k <= 128) ? 100 * k : 12800);
                  if (k == 127) chk("fadein_ramp_on", f_ramp, 1);
                  if (k >= 128) chk("fadein_ramp_off", f_ramp, 0);
               end
            end
            chk("fadein_count", k, 140);
            chk("fadein_und", f_und, 0);
            // saturation
            f_vol = 8'd255; f_sample = 16'sd30000;
            run_strobes(200);
            chk("sat_hi", f_out, 32767);
            f_sample = -16'sd30000;
            run_strobes(40);
            chk("sat_lo", f_out, -32768);
            // back to unity, then mute fade-out
            f_vol = 8'd128; f_sample = 16'sd12800;
            run_strobes(140);
            chk("unity_out", f_out, 12800);
            chk("unity_ramp", f_ramp, 0);
            f_mute = 1'b1;
            run_strobes(64);
            chk("mute_half", f_out, 6400);
            chk("mute_half_flag", f_muted, 0);
            run_strobes(66);
            chk("mute_flag", f_muted, 1);
            chk("mute_out", f_out, 0);
            f_mute = 1'b0;
            // random traffic, alternating well-fed and starved segments
            for (int c = 0; c < 4000; c++) begin
               if (c % 300 == 0) begin
                  f_vol  = 8'($urandom_range(0, 255));
                  f_mute = ($urandom_range(0, 3) == 0);
                  if (c % 600 == 0) f_vol = 8'd255;
               end
               f_valid  = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 8 : 70));
               f_sample = 16'($urandom);
               f_step();
            end
            chk("rand_underruns_seen", f_und > 0, 1);
            // reset in the middle of a fade-in
            f_mute = 1'b0; f_vol = 8'd128; f_valid = 1'b1; f_sample = 16'sd12800;
            f_do_reset();
            for (int c = 0; c < 2000 && m_ticks < 60; c++) f_step();
            chk("midfade_ticks", m_ticks, 60);
            chk("midfade_ramp", f_ramp, 1);
            f_do_reset();
            run_strobes(1);
            chk("refade_out", f_out, 100);
         end
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
